shift_result_serializer: RTL and testbench

- Downstream stage of the shift system.
- Captures each 4-bit result C produced one cycle after a start pulse and buffers results in a small FIFO.
- Transmits each result as a serial MSB-first frame over a valid/ready bit stream toward the output pin/link logic.
- Isolates the single-cycle compute stage from a slower or stalling serial consumer.

---
 rtl/shift_result_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_shift_result_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_result_serializer.sv
// shift_result_serializer
// Captures each W-bit result from the shift stage one clock after its start
// strobe, queues it in a small FIFO and sends it out as an MSB-first serial
// frame over a valid/ready bit stream. The FIFO decouples the single-cycle
// compute stage from a serial consumer that may stall.

module shift_result_serializer #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  C_in,
    input  logic          tx_ready,
    input  logic          clr_ovf,
    output logic          tx_valid,
    output logic          tx_data,
    output logic          tx_sof,
    output logic          tx_eof,
    output logic [AW:0]   fifo_count,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          overflow
);

    // Serializer states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int            BW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] BIT_TOP  = BW'(W - 1);
    localparam logic [BW-1:0] BIT_ZERO = '0;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Registers
    logic              cap_pend_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       cnt_r;
    logic              full_r;
    logic              empty_r;
    logic              ovf_r;
    logic [0:0]        state_r;
    logic [W-1:0]      shreg_r;
    logic [BW-1:0]     bit_cnt_r;
    logic [W-1:0]      mem_r [DEPTH];

    // Next-state / control signals
    logic              push_req_s;
    logic              push_ok_s;
    logic              drop_s;
    logic              pop_s;
    logic [AW:0]       cnt_nxt_s;
    logic              ovf_nxt_s;
    logic [0:0]        state_nxt_s;
    logic [W-1:0]      shreg_nxt_s;
    logic [BW-1:0]     bit_cnt_nxt_s;
    logic [W-1:0]      head_s;

    assign head_s     = mem_r[rd_ptr_r];
    assign push_req_s = cap_pend_r;

    // Serializer FSM: decides pop, frame load, shift and state transitions
    always_comb begin
        pop_s         = 1'b0;
        state_nxt_s   = state_r;
        shreg_nxt_s   = shreg_r;
        bit_cnt_nxt_s = bit_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    pop_s         = 1'b1;
                    shreg_nxt_s   = head_s;
                    bit_cnt_nxt_s = BIT_TOP;
                    state_nxt_s   = ST_SHIFT;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!tx_ready) begin
                    // consumer stalled: hold everything
                    state_nxt_s   = ST_SHIFT;
                end else if (bit_cnt_r != BIT_ZERO) begin
                    shreg_nxt_s   = {shreg_r[W-2:0], 1'b0};
                    bit_cnt_nxt_s = bit_cnt_r - BW'(1);
                end else if (!empty_r) begin
                    // last bit accepted and another result waiting: no gap
                    pop_s         = 1'b1;
                    shreg_nxt_s   = head_s;
                    bit_cnt_nxt_s = BIT_TOP;
                    state_nxt_s   = ST_SHIFT;
                end else begin
                    shreg_nxt_s   = '0;
                    bit_cnt_nxt_s = BIT_ZERO;
                    state_nxt_s   = ST_IDLE;
                end
            end
            default: begin
                shreg_nxt_s   = '0;
                bit_cnt_nxt_s = BIT_ZERO;
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // FIFO admission, occupancy update and sticky overflow flag
    always_comb begin
        // a full FIFO can still take a push when the head leaves on the same edge
        if (push_req_s && ((cnt_r != CNT_FULL) || pop_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
        drop_s = push_req_s & ~push_ok_s;

        case ({push_ok_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
            2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
            default: cnt_nxt_s = cnt_r;
        endcase

        // a new drop takes priority over a clear in the same cycle
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Capture strobe, pointers, occupancy, status flags and serializer state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_pend_r <= 1'b0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cnt_r      <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            ovf_r      <= 1'b0;
            state_r    <= ST_IDLE;
            shreg_r    <= '0;
            bit_cnt_r  <= BIT_ZERO;
        end else begin
            cap_pend_r <= start;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            cnt_r      <= cnt_nxt_s;
            full_r     <= (cnt_nxt_s == CNT_FULL);
            empty_r    <= (cnt_nxt_s == '0);
            ovf_r      <= ovf_nxt_s;
            state_r    <= state_nxt_s;
            shreg_r    <= shreg_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= C_in;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Serial stream outputs decoded from state registers only
    always_comb begin
        if (state_r == ST_SHIFT) begin
            tx_valid = 1'b1;
            tx_data  = shreg_r[W-1];
            tx_sof   = (bit_cnt_r == BIT_TOP);
            tx_eof   = (bit_cnt_r == BIT_ZERO);
        end else begin
            tx_valid = 1'b0;
            tx_data  = 1'b0;
            tx_sof   = 1'b0;
            tx_eof   = 1'b0;
        end
    end

    assign fifo_count = cnt_r;
    assign fifo_full  = full_r;
    assign fifo_empty = empty_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_shift_result_serializer.sv
// Directed self-checking bench for shift_result_serializer.
module tb_shift_result_serializer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] C_in;
    logic       tx_ready;
    logic       clr_ovf;
    logic       tx_valid;
    logic       tx_data;
    logic       tx_sof;
    logic       tx_eof;
    logic [2:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    int checks_r;
    int errors_r;
    int peak_r;

    shift_result_serializer #(.W(4), .DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .C_in       (C_in),
        .tx_ready   (tx_ready),
        .clr_ovf    (clr_ovf),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs and samples sit 1 unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(tx_valid), 32'd0);
        check_eq({tag, "_data"},  32'(tx_data),  32'd0);
        check_eq({tag, "_sof"},   32'(tx_sof),   32'd0);
        check_eq({tag, "_eof"},   32'(tx_eof),   32'd0);
        check_eq({tag, "_count"}, 32'(fifo_count), 32'd0);
        check_eq({tag, "_full"},  32'(fifo_full),  32'd0);
        check_eq({tag, "_empty"}, 32'(fifo_empty), 32'd1);
        check_eq({tag, "_ovf"},   32'(overflow),   32'd0);
    endtask

    // expect n contiguous bits (MSB of the n-bit field first), 4-bit frames
    task automatic expect_bits(input string tag, input logic [31:0] bits, input int n);
        logic [31:0] b;
        b = bits;
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_valid"}, 32'(tx_valid), 32'd1);
            check_eq({tag, "_data"},  32'(tx_data),  32'(b[n-1-i]));
            check_eq({tag, "_sof"},   32'(tx_sof),   32'((i % 4) == 0));
            check_eq({tag, "_eof"},   32'(tx_eof),   32'((i % 4) == 3));
            if (int'(fifo_count) > peak_r) peak_r = int'(fifo_count);
            tick();
        end
    endtask

    initial begin
        checks_r = 0;
        errors_r = 0;
        peak_r   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        C_in     = 4'd0;
        tx_ready = 1'b1;
        clr_ovf  = 1'b0;

        // ---- reset held with random activity on the inputs
        #1;
        for (int i = 0; i < 5; i++) begin
            start    = 1'($urandom_range(0, 1));
            C_in     = 4'($urandom_range(0, 15));
            tx_ready = 1'($urandom_range(0, 1));
            clr_ovf  = 1'($urandom_range(0, 1));
            tick();
            check_reset_outputs("rst_hold");
        end
        start = 1'b0; tx_ready = 1'b1; clr_ovf = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_rel");

        // ---- single frame 0110
        start = 1'b1;
        tick();                       // edge t samples start
        start = 1'b0; C_in = 4'b0110;
        tick();                       // t+1 push
        check_eq("single_count", 32'(fifo_count), 32'd1);
        check_eq("single_prevalid", 32'(tx_valid), 32'd0);
        tick();                       // t+2 pop
        expect_bits("single", 32'b0110, 4);
        check_eq("single_idle", 32'(tx_valid), 32'd0);
        check_eq("single_empty", 32'(fifo_empty), 32'd1);

        // ---- three back-to-back results 0110 0010 0111
        peak_r = 0;
        start = 1'b1;
        tick();                       // t
        C_in = 4'b0110;
        tick();                       // t+1 push 0110
        check_eq("b2b_count1", 32'(fifo_count), 32'd1);
        C_in = 4'b0010;
        tick();                       // t+2 push 0010, pop 0110
        start = 1'b0; C_in = 4'b0111; // pushed at t+3 inside expect_bits
        expect_bits("b2b", 32'b0110_0010_0111, 12);
        check_eq("b2b_peak", 32'(peak_r), 32'd2);
        check_eq("b2b_idle", 32'(tx_valid), 32'd0);
        check_eq("b2b_empty", 32'(fifo_empty), 32'd1);

        // ---- stall three cycles on bit 2 of frame 1011
        start = 1'b1;
        tick();
        start = 1'b0; C_in = 4'b1011;
        tick();
        tick();
        check_eq("stall_b1", 32'(tx_data), 32'd1);
        check_eq("stall_sof1", 32'(tx_sof), 32'd1);
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_valid", 32'(tx_valid), 32'd1);
            check_eq("stall_data",  32'(tx_data),  32'd0);
            check_eq("stall_sof",   32'(tx_sof),   32'd0);
            check_eq("stall_eof",   32'(tx_eof),   32'd0);
            tick();
        end
        tx_ready = 1'b1;
        check_eq("stall_b2_last", 32'(tx_data), 32'd0);
        tick();
        check_eq("stall_b3", 32'(tx_data), 32'd1);
        check_eq("stall_b3_eof", 32'(tx_eof), 32'd0);
        tick();
        check_eq("stall_b4", 32'(tx_data), 32'd1);
        check_eq("stall_b4_eof", 32'(tx_eof), 32'd1);
        tick();
        check_eq("stall_idle", 32'(tx_valid), 32'd0);

        // ---- overflow with the consumer stalled, results 1..6
        tx_ready = 1'b0;
        start = 1'b1;
        tick();                       // t
        for (int k = 1; k <= 6; k++) begin
            C_in = 4'(k);
            if (k == 6) start = 1'b0;
            tick();                   // t+k push result k
            if (k == 5) begin
                check_eq("ovf_count4", 32'(fifo_count), 32'd4);
                check_eq("ovf_full",   32'(fifo_full),  32'd1);
                check_eq("ovf_pre",    32'(overflow),   32'd0);
            end
        end
        check_eq("ovf_set",   32'(overflow),   32'd1);
        check_eq("ovf_count", 32'(fifo_count), 32'd4);
        check_eq("ovf_hold_sof", 32'(tx_sof), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ovf_clr", 32'(overflow), 32'd0);
        // drop and clear in the same cycle: the drop must win
        start = 1'b1;
        tick();
        start = 1'b0; C_in = 4'd9; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ovf_setwins", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ovf_clr2", 32'(overflow), 32'd0);
        tx_ready = 1'b1;
        expect_bits("ovf_drain", 32'h0001_2345, 20);
        check_eq("ovf_idle",  32'(tx_valid),   32'd0);
        check_eq("ovf_empty", 32'(fifo_empty), 32'd1);

        // ---- reset during bit 3 with two results queued
        start = 1'b1;
        tick();
        C_in = 4'b0110;
        tick();
        C_in = 4'b0010;
        tick();                       // bit 1 visible
        start = 1'b0; C_in = 4'b0111;
        tick();                       // bit 2, third result pushed
        tick();                       // bit 3
        check_eq("mid_valid", 32'(tx_valid), 32'd1);
        check_eq("mid_count", 32'(fifo_count), 32'd2);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("post_rst_valid", 32'(tx_valid),   32'd0);
            check_eq("post_rst_empty", 32'(fifo_empty), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
